// File: rtl/sonar_scheduler.sv
// sonar_scheduler
//   Shares one echo-measurement datapath between three HC-SR04 sensors.
//   Sensors are fired one at a time, in the order 0, 1, 2. A guard gap
//   separates consecutive sensors so that one sensor's ping cannot reach
//   the next sensor's receiver. Each echo width is converted to whole
//   centimetres (truncated, saturating at 511). A timeout is reported as
//   511 cm with the timeout flag set. `pronto` pulses once at the end of
//   each round.
//
// Ports
//   clock      in  1   system clock
//   reset      in  1   synchronous, active-high
//   iniciar    in  1   level; rounds repeat while high
//   echo       in  3   raw echo pins (asynchronous), bit i = sensor i
//   trigger    out 3   trigger pins, at most one bit high
//   dist0..2   out 9   last distance per sensor in cm
//   valid      out 3   sensor has a completed measurement
//   timeout    out 3   sensor's last measurement timed out
//   pronto     out 1   one-cycle end-of-round pulse
//   db_estado  out 4   current FSM state
module sonar_scheduler #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GAP_CYCLES     = 3_000_000,
    parameter int PERIOD_CYCLES  = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [2:0] echo,
    output logic [2:0] trigger,
    output logic [8:0] dist0,
    output logic [8:0] dist1,
    output logic [8:0] dist2,
    output logic [2:0] valid,
    output logic [2:0] timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_TRIGGER   = 4'd1,
        S_WAIT_ECHO = 4'd2,
        S_MEASURE   = 4'd3,
        S_STORE     = 4'd4,
        S_GAP       = 4'd5,
        S_DONE      = 4'd6,
        S_PERIOD    = 4'd7
    } state_t;

    // One shared state-cycle counter, sized for the longest wait.
    localparam int MAX_A   = (TRIGGER_CYCLES > TIMEOUT_CYCLES) ? TRIGGER_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_B   = (GAP_CYCLES > PERIOD_CYCLES) ? GAP_CYCLES : PERIOD_CYCLES;
    localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_ALL);
    // CYCLES_PER_CM is assumed to be at least 2.
    localparam int SUB_W   = $clog2(CYCLES_PER_CM);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [8:0]       CM_MAX    = 9'd511;

    state_t           state, state_next;
    logic [1:0]       sel, sel_next;
    logic [CNT_W-1:0] cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic [8:0]       cm;
    logic             timed_out;
    logic             set_timeout;
    logic [2:0]       echo_meta, echo_sync;
    logic             echo_sel;

    assign echo_sel  = echo_sync[sel];
    assign db_estado = state;

    // Next-state logic.
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        sel_next    = sel;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (iniciar) begin
                    sel_next   = 2'd0;
                    state_next = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (cnt == TRIG_LAST) state_next = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                if (echo_sel) begin
                    state_next = S_MEASURE;
                end else if (cnt == TMO_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_STORE;
                end
            end
            S_MEASURE: begin
                if (!echo_sel) begin
                    state_next = S_STORE;
                end else if (cnt == TMO_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = S_STORE;
                end
            end
            S_STORE: begin
                state_next = (sel < 2'd2) ? S_GAP : S_DONE;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    sel_next   = sel + 2'd1;
                    state_next = S_TRIGGER;
                end
            end
            S_DONE: begin
                state_next = iniciar ? S_PERIOD : S_IDLE;
            end
            S_PERIOD: begin
                if (!iniciar) begin
                    state_next = S_IDLE;
                end else if (cnt == PER_LAST) begin
                    sel_next   = 2'd0;
                    state_next = S_TRIGGER;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            sel   <= 2'd0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    // Datapath: synchronizer, counters, result registers, outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_meta <= 3'b000;
            echo_sync <= 3'b000;
            cnt       <= '0;
            sub_cnt   <= '0;
            cm        <= 9'd0;
            timed_out <= 1'b0;
            dist0     <= 9'd0;
            dist1     <= 9'd0;
            dist2     <= 9'd0;
            valid     <= 3'b000;
            timeout   <= 3'b000;
            trigger   <= 3'b000;
            pronto    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;

            // Counts clocks spent in the current state.
            if (state_next != state || state == S_IDLE) cnt <= '0;
            else                                        cnt <= cnt + CNT_W'(1);

            // The clock that sees echo rise in WAIT_ECHO is itself the first
            // high clock, so the sub-counter restarts at 1 to measure the
            // full width.
            if (state == S_WAIT_ECHO && state_next == S_MEASURE) begin
                sub_cnt <= SUB_W'(1);
                cm      <= 9'd0;
            end else if (state == S_MEASURE && echo_sel) begin
                if (sub_cnt == SUB_LAST) begin
                    sub_cnt <= '0;
                    if (cm != CM_MAX) cm <= cm + 9'd1;
                end else begin
                    sub_cnt <= sub_cnt + SUB_W'(1);
                end
            end

            if (set_timeout)           timed_out <= 1'b1;
            else if (state == S_STORE) timed_out <= 1'b0;

            if (state == S_STORE) begin
                case (sel)
                    2'd0:    dist0 <= timed_out ? CM_MAX : cm;
                    2'd1:    dist1 <= timed_out ? CM_MAX : cm;
                    default: dist2 <= timed_out ? CM_MAX : cm;
                endcase
                timeout[sel] <= timed_out;
                valid[sel]   <= 1'b1;
            end

            // Pins are registered from the next state so they are glitch
            // free and line up exactly with the state they belong to.
            trigger <= (state_next == S_TRIGGER) ? (3'b001 << sel_next) : 3'b000;
            pronto  <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler
//   Randomized self-checking bench for sonar_scheduler with shrunk timing
//   parameters. A behavioural model derives each sensor's expected result
//   from the echo it was given (width / CYCLES_PER_CM, saturation, timeout).
module tb_sonar_scheduler;

    localparam int TRIG  = 4;
    localparam int CPCM  = 5;
    localparam int TMO   = 3000;
    localparam int GAP   = 16;
    localparam int PER   = 40;
    localparam int BOUND = 10000;

    localparam int ST_IDLE    = 0;
    localparam int ST_TRIGGER = 1;
    localparam int ST_WAIT    = 2;
    localparam int ST_MEASURE = 3;
    localparam int ST_GAP     = 5;
    localparam int ST_DONE    = 6;
    localparam int ST_PERIOD  = 7;

    typedef enum int {E_PULSE, E_NONE, E_STUCK} echo_mode_e;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [2:0] echo;
    logic [2:0] trigger;
    logic [8:0] dist0, dist1, dist2;
    logic [2:0] valid;
    logic [2:0] timeout;
    logic       pronto;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    sonar_scheduler #(
        .TRIGGER_CYCLES(TRIG),
        .CYCLES_PER_CM (CPCM),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .PERIOD_CYCLES (PER)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .echo     (echo),
        .trigger  (trigger),
        .dist0    (dist0),
        .dist1    (dist1),
        .dist2    (dist2),
        .valid    (valid),
        .timeout  (timeout),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state and the current round's plan.
    int         exp_dist [3];
    logic [2:0] exp_valid;
    logic [2:0] exp_to;
    echo_mode_e plan_mode  [3];
    int         plan_delay [3];
    int         plan_width [3];
    bit         plan_xt;
    bit         plan_drop;
    bit         plan_per_drop;
    bit         overlap_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!$onehot0(trigger)) overlap_seen = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] dist_of(input int s);
        case (s)
            0:       return dist0;
            1:       return dist1;
            default: return dist2;
        endcase
    endfunction

    // Expected result of one sensor slot, from the echo it received.
    function automatic void model_slot(input int s);
        if (plan_mode[s] != E_PULSE || plan_width[s] > TMO) begin
            exp_dist[s] = 511;
            exp_to[s]   = 1'b1;
        end else begin
            exp_dist[s] = (plan_width[s] / CPCM > 511) ? 511 : plan_width[s] / CPCM;
            exp_to[s]   = 1'b0;
        end
        exp_valid[s] = 1'b1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) exp_dist[i] = 0;
        exp_valid = 3'b000;
        exp_to    = 3'b000;
    endfunction

    task automatic set_slot(input int s, input echo_mode_e m, input int d, input int w);
        plan_mode[s]  = m;
        plan_delay[s] = d;
        plan_width[s] = w;
    endtask

    task automatic count_state(input int st, output int n);
        n = 0;
        while (int'(db_estado) == st && n < BOUND) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_state(input int st, input string tag);
        int n = 0;
        while (int'(db_estado) != st && n < BOUND) begin
            n++;
            @(negedge clock);
        end
        check(tag, db_estado, st);
    endtask

    task automatic wait_trigger(input int s);
        int n = 0;
        while (trigger == 3'b000 && n < BOUND) begin
            n++;
            @(negedge clock);
        end
        check($sformatf("trig_sel%0d", s), trigger, 32'(1) << s);
    endtask

    task automatic drive_echo(input int s);
        int n;
        case (plan_mode[s])
            E_NONE: begin
                count_state(ST_WAIT, n);
                check($sformatf("wait_len%0d", s), n, TMO);
            end
            E_STUCK: begin
                repeat (plan_delay[s]) @(negedge clock);
                echo[s] = 1'b1;
                wait_state(ST_MEASURE, "reach_measure");
                count_state(ST_MEASURE, n);
                check($sformatf("measure_len%0d", s), n, TMO);
            end
            default: begin
                repeat (plan_delay[s]) @(negedge clock);
                for (int k = 0; k < plan_width[s]; k++) begin
                    echo[s] = 1'b1;
                    if (plan_xt && s == 0) begin
                        echo[1] = (k >= 2 && k < plan_width[s] - 3);
                        echo[2] = (k >= 2 && k < plan_width[s] - 3);
                    end
                    @(negedge clock);
                end
                echo = 3'b000;
            end
        endcase
    endtask

    task automatic run_round();
        int n;
        for (int s = 0; s < 3; s++) begin
            if (s == 1 && plan_drop) iniciar = 1'b0;
            wait_trigger(s);
            n = 0;
            while (trigger[s] === 1'b1 && n < BOUND) begin
                n++;
                @(negedge clock);
            end
            check($sformatf("trig_len%0d", s), n, TRIG);
            drive_echo(s);
            n = 0;
            while (int'(db_estado) != ST_GAP && int'(db_estado) != ST_DONE && n < BOUND) begin
                n++;
                @(negedge clock);
            end
            check($sformatf("after_store%0d", s), db_estado, (s < 2) ? ST_GAP : ST_DONE);
            model_slot(s);
            check($sformatf("dist0_s%0d", s), dist0, exp_dist[0]);
            check($sformatf("dist1_s%0d", s), dist1, exp_dist[1]);
            check($sformatf("dist2_s%0d", s), dist2, exp_dist[2]);
            check($sformatf("valid_s%0d", s), valid, exp_valid);
            check($sformatf("timeout_s%0d", s), timeout, exp_to);
            if (s < 2) begin
                count_state(ST_GAP, n);
                check($sformatf("gap_len%0d", s), n, GAP);
            end
        end
        check("pronto_high", pronto, 1);
        @(negedge clock);
        check("pronto_low", pronto, 0);
        echo = 3'b000;
        if (plan_per_drop) begin
            check("period_entry", db_estado, ST_PERIOD);
            repeat (5) @(negedge clock);
            iniciar = 1'b0;
            @(negedge clock);
            check("period_abort", db_estado, ST_IDLE);
        end else if (iniciar) begin
            count_state(ST_PERIOD, n);
            check("period_len", n, PER);
        end else begin
            check("idle_after_done", db_estado, ST_IDLE);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   db_estado, 0);
        check({tag, "_trigger"}, trigger, 0);
        check({tag, "_dist0"},   dist0, 0);
        check({tag, "_dist1"},   dist1, 0);
        check({tag, "_dist2"},   dist2, 0);
        check({tag, "_valid"},   valid, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_pronto"},  pronto, 0);
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        iniciar       = 1'b0;
        echo          = 3'b000;
        plan_xt       = 1'b0;
        plan_drop     = 1'b0;
        plan_per_drop = 1'b0;
        model_clear();
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);
        check("idle_hold", db_estado, ST_IDLE);

        // Start: trigger rises right after iniciar is sampled.
        iniciar = 1'b1;
        @(negedge clock);
        check("start_latency", trigger, 3'b001);

        // Basic round: exact multiple of CYCLES_PER_CM.
        for (int s = 0; s < 3; s++) set_slot(s, E_PULSE, 8, 500);
        run_round();

        // Truncation and mixed widths.
        set_slot(0, E_PULSE, 3, 374);
        set_slot(1, E_PULSE, 11, 504);
        set_slot(2, E_PULSE, 0, 104);
        run_round();

        // Timeouts: no echo on sensor 1, echo stuck high on sensor 2.
        set_slot(0, E_PULSE, 5, 50);
        set_slot(1, E_NONE, 0, 0);
        set_slot(2, E_STUCK, 5, 0);
        run_round();

        // Crosstalk on echo[1]/echo[2] while sensor 0 measures.
        plan_xt = 1'b1;
        set_slot(0, E_PULSE, 4, 300);
        set_slot(1, E_PULSE, 6, 60);
        set_slot(2, E_PULSE, 2, 77);
        run_round();
        plan_xt = 1'b0;

        // Saturation at 511 without timeout, and a sub-centimetre echo.
        set_slot(0, E_PULSE, 2, 2700);
        set_slot(1, E_PULSE, 9, 27);
        set_slot(2, E_PULSE, 1, 4);
        run_round();

        // Random rounds; iniciar drops during sensor 1 of the last one.
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 3; s++) begin
                int pick = $urandom_range(0, 9);
                echo_mode_e m = (pick == 0) ? E_NONE : (pick == 1) ? E_STUCK : E_PULSE;
                set_slot(s, m, $urandom_range(0, 30), $urandom_range(1, 800));
            end
            plan_drop = (r == 5);
            run_round();
        end
        plan_drop = 1'b0;

        // No further triggers once idle.
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (trigger != 3'b000) n++;
            @(negedge clock);
        end
        check("idle_no_trigger", n, 0);

        // Restart, then drop iniciar during PERIOD.
        iniciar = 1'b1;
        @(negedge clock);
        check("restart_latency", trigger, 3'b001);
        for (int s = 0; s < 3; s++) set_slot(s, E_PULSE, $urandom_range(0, 20), $urandom_range(1, 400));
        plan_per_drop = 1'b1;
        run_round();
        plan_per_drop = 1'b0;

        // Reset asserted for one clock in the middle of MEASURE.
        iniciar = 1'b1;
        wait_trigger(0);
        n = 0;
        while (trigger[0] === 1'b1 && n < BOUND) begin
            n++;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        echo[0] = 1'b1;
        wait_state(ST_MEASURE, "reset_reach_measure");
        repeat (10) @(negedge clock);
        check("pre_reset_valid", valid, 3'b111);
        reset   = 1'b1;
        iniciar = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        echo  = 3'b000;
        model_clear();
        check_reset_values("midreset");
        @(negedge clock);
        check("post_reset_idle", db_estado, ST_IDLE);

        check("trigger_onehot", overlap_seen, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
